// File: rtl/axi4_lite_register_pkg.sv
`default_nettype none
// ============================================================================
// Module      : axi4_lite_register_pkg
// Description : Shared types and helpers for the AXI4-lite register
//               controller: response codes, FSM state encoding and the
//               address -> register-index / error decode.
// Revision    : 1.0 - initial release
// ============================================================================
package axi4_lite_register_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [2:0] {
    IDLE         = 3'd0,
    WR_ADDR_DATA = 3'd1,
    WR_COMMIT    = 3'd2,
    WR_RESP      = 3'd3,
    RD_STROBE    = 3'd4,
    RD_RESP      = 3'd5
  } state_t;

  // Register index: the MW bits sitting just above the byte-offset bits.
  function automatic logic [31:0] reg_index(input logic [63:0] addr,
                                            input int unsigned lo,
                                            input int unsigned mw);
    return 32'((addr >> lo) & ((64'd1 << mw) - 64'd1));
  endfunction

  // Any set bit above the index field addresses nothing in the bank.
  function automatic logic addr_error(input logic [63:0] addr,
                                      input int unsigned lo,
                                      input int unsigned mw);
    return (addr >> (lo + mw)) != 64'd0;
  endfunction

endpackage
`default_nettype wire

// File: rtl/axi4_lite_register_controller.sv
`default_nettype none
// ============================================================================
// Module      : axi4_lite_register_controller
// Description : AXI4-lite slave front end for a bank of MI registers.
//               Terminates AW/W/B and AR/R, arbitrates read vs write with a
//               round-robin pointer, runs one transaction at a time and
//               drives one-cycle wr_en/rd_en strobes. Writes are merged into
//               register_out byte by byte under wstrb.
// Ports       : aclk/areset          clock, synchronous active-high reset
//               aw*/w*/b*            AXI write address/data/response
//               ar*/r*               AXI read address/data
//               register_in  [MI]    read-back value per register
//               register_out [MI]    stored register values
//               wr_en/rd_en  [MI]    one-cycle strobes
//               wdata                last committed write data (unmasked)
// Revision    : 1.0 - initial release
// ============================================================================
module axi4_lite_register_controller
  import axi4_lite_register_pkg::*;
#(
  parameter int N      = 8,
  parameter int MW     = 3,
  parameter int MI     = 2**MW,
  parameter int ADDR_W = 12
) (
  input  logic                       aclk,
  input  logic                       areset,
  input  logic [ADDR_W-1:0]          awaddr,
  input  logic                       awvalid,
  output logic                       awready,
  input  logic [8*N-1:0]             wdata_in,
  input  logic [N-1:0]               wstrb,
  input  logic                       wvalid,
  output logic                       wready,
  output logic [1:0]                 bresp,
  output logic                       bvalid,
  input  logic                       bready,
  input  logic [ADDR_W-1:0]          araddr,
  input  logic                       arvalid,
  output logic                       arready,
  output logic [8*N-1:0]             rdata,
  output logic [1:0]                 rresp,
  output logic                       rvalid,
  input  logic                       rready,
  input  logic [MI-1:0][8*N-1:0]     register_in,
  output logic [MI-1:0][8*N-1:0]     register_out,
  output logic [MI-1:0]              wr_en,
  output logic [MI-1:0]              rd_en,
  output logic [8*N-1:0]             wdata
);

  localparam int LO = $clog2(N);

  if (!(N == 4 || N == 8)) begin : g_bad_width
    $fatal(1, "axi4_lite_register_controller: N must be 4 or 8");
  end
  if (ADDR_W < MW + LO) begin : g_bad_addr
    $fatal(1, "axi4_lite_register_controller: ADDR_W too small");
  end

  state_t              state;
  state_t              state_next;
  logic                rr_write_first;
  logic                grant_write;
  logic                grant_read;
  logic                aw_done;
  logic                w_done;
  logic [ADDR_W-1:0]   waddr_q;
  logic [8*N-1:0]      wdata_q;
  logic [N-1:0]        wstrb_q;
  logic [ADDR_W-1:0]   raddr_q;

  logic                aw_hs;
  logic                w_hs;
  logic                ar_hs;
  logic [MW-1:0]       w_idx;
  logic                w_err;
  logic [MW-1:0]       r_idx;
  logic                r_err;
  logic [8*N-1:0]      cur_reg;
  logic [8*N-1:0]      merged;

  assign aw_hs = awvalid & awready;
  assign w_hs  = wvalid  & wready;
  assign ar_hs = arvalid & arready;

  assign w_idx = MW'(reg_index(64'(waddr_q), LO, MW));
  assign w_err = addr_error(64'(waddr_q), LO, MW);
  assign r_idx = MW'(reg_index(64'(raddr_q), LO, MW));
  assign r_err = addr_error(64'(raddr_q), LO, MW);

  // Byte-strobe merge of the captured write into the addressed register.
  assign cur_reg = register_out[w_idx];
  for (genvar k = 0; k < N; k++) begin : g_byte_merge
    assign merged[8*k +: 8] = wstrb_q[k] ? wdata_q[8*k +: 8] : cur_reg[8*k +: 8];
  end

  // State register
  always_ff @(posedge aclk) begin
    if (areset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next state and handshake/strobe outputs
  always_comb begin
    state_next  = state;
    grant_write = 1'b0;
    grant_read  = 1'b0;
    awready     = 1'b0;
    wready      = 1'b0;
    arready     = 1'b0;
    bvalid      = 1'b0;
    rvalid      = 1'b0;
    wr_en       = '0;
    rd_en       = '0;
    case (state)
      IDLE: begin
        // Either write channel being valid counts as a write request;
        // the pointer only matters when a read competes with it.
        if ((awvalid || wvalid) && (!arvalid || rr_write_first)) begin
          grant_write = 1'b1;
          state_next  = WR_ADDR_DATA;
        end else if (arvalid) begin
          grant_read  = 1'b1;
          arready     = 1'b1;
          state_next  = RD_STROBE;
        end
      end
      WR_ADDR_DATA: begin
        awready = !aw_done;
        wready  = !w_done;
        if ((aw_done || awvalid) && (w_done || wvalid)) begin
          state_next = WR_COMMIT;
        end
      end
      WR_COMMIT: begin
        if (!w_err) begin
          wr_en[w_idx] = 1'b1;
        end
        state_next = WR_RESP;
      end
      WR_RESP: begin
        bvalid = 1'b1;
        if (bready) begin
          state_next = IDLE;
        end
      end
      RD_STROBE: begin
        if (!r_err) begin
          rd_en[r_idx] = 1'b1;
        end
        state_next = RD_RESP;
      end
      RD_RESP: begin
        rvalid = 1'b1;
        if (rready) begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Datapath: channel capture, register bank, response registers
  always_ff @(posedge aclk) begin
    if (areset) begin
      rr_write_first <= 1'b1;
      aw_done        <= 1'b0;
      w_done         <= 1'b0;
      waddr_q        <= '0;
      wdata_q        <= '0;
      wstrb_q        <= '0;
      raddr_q        <= '0;
      bresp          <= RESP_OKAY;
      rresp          <= RESP_OKAY;
      rdata          <= '0;
      register_out   <= '0;
      wdata          <= '0;
    end else begin
      if (grant_write || grant_read) begin
        rr_write_first <= ~rr_write_first;
      end
      if (aw_hs) begin
        waddr_q <= awaddr;
        aw_done <= 1'b1;
      end
      if (w_hs) begin
        wdata_q <= wdata_in;
        wstrb_q <= wstrb;
        w_done  <= 1'b1;
      end
      if (ar_hs) begin
        raddr_q <= araddr;
      end
      if (state == WR_COMMIT) begin
        aw_done <= 1'b0;
        w_done  <= 1'b0;
        wdata   <= wdata_q;
        bresp   <= w_err ? RESP_SLVERR : RESP_OKAY;
        if (!w_err) begin
          register_out[w_idx] <= merged;
        end
      end
      if (state == RD_STROBE) begin
        rresp <= r_err ? RESP_SLVERR : RESP_OKAY;
        rdata <= r_err ? '0 : register_in[r_idx];
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_axi4_lite_register_controller.sv
`default_nettype none
// ============================================================================
// Module      : tb_axi4_lite_register_controller
// Description : Directed self-checking bench for the AXI4-lite register
//               controller (N=8, MW=3, ADDR_W=12).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_axi4_lite_register_controller;

  localparam int N      = 8;
  localparam int MW     = 3;
  localparam int MI     = 8;
  localparam int ADDR_W = 12;

  logic                    aclk = 1'b0;
  logic                    areset;
  logic [ADDR_W-1:0]       awaddr;
  logic                    awvalid;
  logic                    awready;
  logic [8*N-1:0]          wdata_in;
  logic [N-1:0]            wstrb;
  logic                    wvalid;
  logic                    wready;
  logic [1:0]              bresp;
  logic                    bvalid;
  logic                    bready;
  logic [ADDR_W-1:0]       araddr;
  logic                    arvalid;
  logic                    arready;
  logic [8*N-1:0]          rdata;
  logic [1:0]              rresp;
  logic                    rvalid;
  logic                    rready;
  logic [MI-1:0][8*N-1:0]  register_in;
  logic [MI-1:0][8*N-1:0]  register_out;
  logic [MI-1:0]           wr_en;
  logic [MI-1:0]           rd_en;
  logic [8*N-1:0]          wdata;

  logic [MI-1:0][8*N-1:0]  exp_regs;

  int checks   = 0;
  int failures = 0;

  always #5 aclk = ~aclk;

  axi4_lite_register_controller #(
    .N(N), .MW(MW), .MI(MI), .ADDR_W(ADDR_W)
  ) dut (
    .aclk(aclk), .areset(areset),
    .awaddr(awaddr), .awvalid(awvalid), .awready(awready),
    .wdata_in(wdata_in), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
    .bresp(bresp), .bvalid(bvalid), .bready(bready),
    .araddr(araddr), .arvalid(arvalid), .arready(arready),
    .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready),
    .register_in(register_in), .register_out(register_out),
    .wr_en(wr_en), .rd_en(rd_en), .wdata(wdata)
  );

  task automatic idle_inputs();
    awaddr = '0; awvalid = 1'b0; wdata_in = '0; wstrb = '0; wvalid = 1'b0;
    bready = 1'b0; araddr = '0; arvalid = 1'b0; rready = 1'b0;
  endtask

  task automatic test_reset();
    areset = 1'b1;
    idle_inputs();
    register_in = '0;
    exp_regs = '0;
    repeat (3) @(negedge aclk);
    checks++;
    if ({awready, wready, arready, bvalid, rvalid} !== 5'b0) begin
      failures++;
      $display("FAIL reset_handshake: got %b expected 00000", {awready, wready, arready, bvalid, rvalid});
    end
    checks++;
    if ({bresp, rresp, rdata, wdata, wr_en, rd_en} !== '0) begin
      failures++;
      $display("FAIL reset_outputs: got bresp=%b rresp=%b rdata=%h wdata=%h wr_en=%b rd_en=%b expected all 0",
               bresp, rresp, rdata, wdata, wr_en, rd_en);
    end
    checks++;
    if (register_out !== exp_regs) begin
      failures++;
      $display("FAIL reset_regs: got %h expected 0", register_out);
    end
    areset = 1'b0;
    @(negedge aclk);
  endtask

  // Write with AW and W presented together; checks strobe, response and merge.
  task automatic test_write_full(input logic [ADDR_W-1:0] addr, input logic [63:0] data,
                                 input logic [7:0] strb, input logic [MI-1:0] exp_wr,
                                 input logic [1:0] exp_resp);
    int n = 0;
    awaddr = addr; awvalid = 1'b1; wdata_in = data; wstrb = strb; wvalid = 1'b1; bready = 1'b0;
    while (!(awready && wready) && n < 10) begin
      @(negedge aclk);
      n++;
    end
    checks++;
    if (n >= 10) begin
      failures++;
      $display("FAIL write_ready_timeout: got awready=%b wready=%b expected 1 1", awready, wready);
    end
    @(negedge aclk);
    awvalid = 1'b0; wvalid = 1'b0;
    checks++;
    if (wr_en !== exp_wr || bvalid !== 1'b0) begin
      failures++;
      $display("FAIL write_strobe: got wr_en=%b bvalid=%b expected wr_en=%b bvalid=0", wr_en, bvalid, exp_wr);
    end
    @(negedge aclk);
    checks++;
    if (bvalid !== 1'b1 || bresp !== exp_resp || wr_en !== '0) begin
      failures++;
      $display("FAIL write_resp: got bvalid=%b bresp=%b wr_en=%b expected 1 %b 0", bvalid, bresp, wr_en, exp_resp);
    end
    checks++;
    if (register_out !== exp_regs) begin
      failures++;
      $display("FAIL write_regs: got %h expected %h", register_out, exp_regs);
    end
    checks++;
    if (wdata !== data) begin
      failures++;
      $display("FAIL write_wdata: got %h expected %h", wdata, data);
    end
    bready = 1'b1;
    @(negedge aclk);
    bready = 1'b0;
    checks++;
    if (bvalid !== 1'b0) begin
      failures++;
      $display("FAIL write_bvalid_drop: got %b expected 0", bvalid);
    end
  endtask

  // W handshakes three cycles ahead of AW, partial strobe.
  task automatic test_write_partial();
    wdata_in = 64'h1122_3344_5566_7788; wstrb = 8'h0F; wvalid = 1'b1; bready = 1'b0;
    @(negedge aclk);
    checks++;
    if (wready !== 1'b1 || awready !== 1'b1) begin
      failures++;
      $display("FAIL partial_ready: got wready=%b awready=%b expected 1 1", wready, awready);
    end
    @(negedge aclk);
    wvalid = 1'b0;
    checks++;
    if (wready !== 1'b0 || awready !== 1'b1 || wr_en !== '0) begin
      failures++;
      $display("FAIL partial_w_captured: got wready=%b awready=%b wr_en=%b expected 0 1 0", wready, awready, wr_en);
    end
    repeat (2) @(negedge aclk);
    awaddr = 12'h018; awvalid = 1'b1;
    @(negedge aclk);
    awvalid = 1'b0;
    checks++;
    if (wr_en !== 8'h08) begin
      failures++;
      $display("FAIL partial_strobe: got %b expected 00001000", wr_en);
    end
    @(negedge aclk);
    exp_regs[3] = 64'h0000_0000_5566_7788;
    checks++;
    if (register_out !== exp_regs || bvalid !== 1'b1 || bresp !== 2'b00) begin
      failures++;
      $display("FAIL partial_merge: got reg3=%h bvalid=%b bresp=%b expected %h 1 00",
               register_out[3], bvalid, bresp, exp_regs[3]);
    end
    checks++;
    if (wdata !== 64'h1122_3344_5566_7788) begin
      failures++;
      $display("FAIL partial_wdata: got %h expected 1122334455667788", wdata);
    end
    bready = 1'b1;
    @(negedge aclk);
    bready = 1'b0;
  endtask

  task automatic test_read(input logic [ADDR_W-1:0] addr, input logic [MI-1:0] exp_rd,
                           input logic [63:0] exp_data, input logic [1:0] exp_resp);
    araddr = addr; arvalid = 1'b1; rready = 1'b0;
    #1;
    checks++;
    if (arready !== 1'b1) begin
      failures++;
      $display("FAIL read_arready: got %b expected 1", arready);
    end
    @(negedge aclk);
    arvalid = 1'b0;
    checks++;
    if (rd_en !== exp_rd || rvalid !== 1'b0 || arready !== 1'b0) begin
      failures++;
      $display("FAIL read_strobe: got rd_en=%b rvalid=%b arready=%b expected %b 0 0", rd_en, rvalid, arready, exp_rd);
    end
    @(negedge aclk);
    checks++;
    if (rvalid !== 1'b1 || rdata !== exp_data || rresp !== exp_resp || rd_en !== '0) begin
      failures++;
      $display("FAIL read_resp: got rvalid=%b rdata=%h rresp=%b rd_en=%b expected 1 %h %b 0",
               rvalid, rdata, rresp, rd_en, exp_data, exp_resp);
    end
    register_in[4] = 64'h1234;
    for (int i = 0; i < 5; i++) begin
      @(negedge aclk);
      checks++;
      if (rvalid !== 1'b1 || rdata !== exp_data || rresp !== exp_resp) begin
        failures++;
        $display("FAIL read_hold: got rvalid=%b rdata=%h rresp=%b expected 1 %h %b", rvalid, rdata, rresp, exp_data, exp_resp);
      end
    end
    register_in[4] = 64'hCAFE;
    rready = 1'b1;
    @(negedge aclk);
    rready = 1'b0;
    checks++;
    if (rvalid !== 1'b0) begin
      failures++;
      $display("FAIL read_rvalid_drop: got %b expected 0", rvalid);
    end
  endtask

  task automatic test_round_robin();
    byte ev[4];
    byte exp_ev[4];
    int  nev = 0;
    int  overlap = 0;
    exp_ev[0] = "W"; exp_ev[1] = "R"; exp_ev[2] = "W"; exp_ev[3] = "R";
    areset = 1'b1;
    awaddr = 12'h008; araddr = 12'h010; wdata_in = 64'hFFFF; wstrb = 8'h00;
    awvalid = 1'b1; wvalid = 1'b1; arvalid = 1'b1; bready = 1'b1; rready = 1'b1;
    exp_regs = '0;
    repeat (2) @(negedge aclk);
    areset = 1'b0;
    for (int c = 0; c < 40; c++) begin
      @(negedge aclk);
      if (wr_en != '0 && rd_en != '0) overlap++;
      if (nev < 4 && wr_en != '0) begin
        ev[nev] = "W";
        nev++;
        checks++;
        if (wr_en !== 8'h02) begin
          failures++;
          $display("FAIL rr_wr_en: got %b expected 00000010", wr_en);
        end
      end else if (nev < 4 && rd_en != '0) begin
        ev[nev] = "R";
        nev++;
        checks++;
        if (rd_en !== 8'h04) begin
          failures++;
          $display("FAIL rr_rd_en: got %b expected 00000100", rd_en);
        end
      end
    end
    checks++;
    if (nev < 4) begin
      failures++;
      $display("FAIL rr_event_timeout: got %0d events expected 4", nev);
    end else begin
      for (int i = 0; i < 4; i++) begin
        checks++;
        if (ev[i] !== exp_ev[i]) begin
          failures++;
          $display("FAIL rr_order[%0d]: got %c expected %c", i, ev[i], exp_ev[i]);
        end
      end
    end
    checks++;
    if (overlap !== 0) begin
      failures++;
      $display("FAIL rr_overlap: got %0d cycles expected 0", overlap);
    end
    checks++;
    if (register_out !== exp_regs) begin
      failures++;
      $display("FAIL rr_zero_strobe_regs: got %h expected 0", register_out);
    end
    idle_inputs();
    areset = 1'b1;
    repeat (2) @(negedge aclk);
    areset = 1'b0;
    @(negedge aclk);
  endtask

  task automatic test_reset_mid();
    int n = 0;
    awaddr = 12'h008; awvalid = 1'b1; wdata_in = 64'hABCD; wstrb = 8'hFF; wvalid = 1'b1; bready = 1'b0;
    while (!bvalid && n < 10) begin
      @(negedge aclk);
      n++;
      if (!awready && !wready) begin
        awvalid = 1'b0; wvalid = 1'b0;
      end
    end
    checks++;
    if (n >= 10 || register_out[1] !== 64'hABCD) begin
      failures++;
      $display("FAIL midreset_setup: got bvalid=%b reg1=%h expected 1 000000000000abcd", bvalid, register_out[1]);
    end
    awvalid = 1'b0; wvalid = 1'b0;
    areset = 1'b1;
    @(negedge aclk);
    checks++;
    if (bvalid !== 1'b0 || register_out !== '0 || wdata !== '0) begin
      failures++;
      $display("FAIL midreset_abort: got bvalid=%b regs=%h wdata=%h expected 0 0 0", bvalid, register_out, wdata);
    end
    areset = 1'b0;
    @(negedge aclk);
    checks++;
    if (bvalid !== 1'b0 || wr_en !== '0) begin
      failures++;
      $display("FAIL midreset_after: got bvalid=%b wr_en=%b expected 0 0", bvalid, wr_en);
    end
  endtask

  initial begin
    test_reset();
    exp_regs[2] = 64'h0000_0000_DEAD_BEEF;
    test_write_full(12'h010, 64'h0000_0000_DEAD_BEEF, 8'hFF, 8'h04, 2'b00);
    test_write_partial();
    register_in[4] = 64'hCAFE;
    test_read(12'h020, 8'h10, 64'hCAFE, 2'b00);
    test_write_full(12'h400, 64'hFFFF_FFFF_FFFF_FFFF, 8'hFF, 8'h00, 2'b10);
    test_read(12'h400, 8'h00, 64'h0, 2'b10);
    test_round_robin();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
